poly_eval_fire_scheduler: RTL and testbench
===========================================

Name: poly_eval_fire_scheduler

Overview:
Parent CFDF scheduler for the firing-state FSM2 datapath. It alternates SETUP_INSTR and INSTR firings, and evaluates each mode's enable condition from token availability and output-FIFO free space before issuing start_fsm2. It then waits for done_fsm2, with a watchdog, and keeps firing statistics. It sits between the top-level actor wrapper and firing_state_FSM2.

Parameters:
word_size, 16, width of population/availability counts and arg fields
timeout_cycles, 4096, max cycles allowed between start_fsm2 and done_fsm2
cnt_width, 16, width of fire_count

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
run  input  1  level; scheduler may issue firings while high
pop_cmd  input  word_size  command tokens available (FIFO population + unread RAM)
data_avail  input  word_size  data tokens available to the instruction datapath
out_free  input  word_size  free slots in output result/status FIFOs (min of both)
instr  input  8  decoded instruction from FSM2 (STP=0, EVP=1, EVB=2, RST=3)
arg2  input  5  decoded arg2 (N for STP, b for EVB)
done_fsm2  input  1  one-cycle completion pulse from FSM2
start_fsm2  output  1  one-cycle firing request to FSM2
next_instr  output  2  firing mode: 00 SETUP_INSTR, 01 INSTR
busy  output  1  high from start_fsm2 until done_fsm2/timeout
timeout_err  output  1  sticky watchdog error
bad_instr  output  1  sticky: instr outside 0..3 seen in CHECK_INSTR
fire_count  output  cnt_width  completed firings (both modes), wraps

Behaviour:
- Reset (rst low, async): state IDLE; start_fsm2=0, next_instr=00, busy=0, timeout_err=0, bad_instr=0, fire_count=0, watchdog=0.
- States: IDLE, CHECK_SETUP, FIRE_SETUP, WAIT_SETUP, CHECK_INSTR, FIRE_INSTR, WAIT_INSTR, HALT.
- IDLE: if run, go to CHECK_SETUP next cycle.
- CHECK_SETUP: if !run -> IDLE; else if pop_cmd>=1 -> FIRE_SETUP; else stay.
- FIRE_SETUP: start_fsm2=1 for exactly this cycle, next_instr=00, busy=1 -> WAIT_SETUP.
- WAIT_SETUP: next_instr held at 00, busy=1.
  - done_fsm2 -> CHECK_INSTR, fire_count+1.
  - Watchdog reaching timeout_cycles-1 without done -> HALT, timeout_err=1.
- CHECK_INSTR: enable rules, evaluated combinationally on the current inputs:
  - STP: data_avail >= arg2+1 (compare at word_size+1 bits, no overflow).
  - EVP: data_avail>=1 and out_free>=1.
  - EVB: data_avail>=arg2 and out_free>=arg2; arg2=0 means enabled if out_free>=1.
  - RST: always enabled.
  - instr>3: bad_instr=1 -> CHECK_SETUP (command discarded, no firing, no count).
  - run low: stays in CHECK_INSTR; the decoded command is never dropped.
  - Enabled and run high -> FIRE_INSTR.
- FIRE_INSTR: start_fsm2=1 for one cycle, next_instr=01, busy=1 -> WAIT_INSTR.
- WAIT_INSTR: next_instr held at 01, busy=1.
  - done_fsm2 -> CHECK_SETUP, fire_count+1.
  - Watchdog as in WAIT_SETUP.
- Watchdog: cleared on the FIRE_* cycle, increments each WAIT_* cycle. done_fsm2 takes priority over timeout in the same cycle.
- done_fsm2 outside WAIT_* is ignored: no count, no state change.
- HALT: start_fsm2=0, busy=0; leaves only via reset. timeout_err and bad_instr clear only on reset.
- next_instr keeps its last value in CHECK_* and IDLE. It is stable from FIRE_* through done.
- All outputs are registered. The earliest start_fsm2 is 2 cycles after run rises with pop_cmd>=1.
- Reset mid-operation returns to IDLE immediately. FSM2 is reset by the same rst.

Decomposition:
- Shared package/header holds mode constants SETUP_INSTR/INSTR/OUTPUT, opcode constants STP/EVP/EVB/RST, the log2 function and the state encodings.
- One sub-module is natural: fire_enable_check, a combinational per-opcode token/space check producing enable and bad_instr.
- The watchdog counter stays inline.

Test Plan:
1. Reset, run=1, pop_cmd=1, FSM2 model returns done 5 cycles after start -> start_fsm2 pulse with next_instr=00 at cycle 2, busy for 6 cycles, fire_count=1.
2. instr=STP, arg2=4, data_avail=4 -> no start; raise data_avail to 5 -> start_fsm2 with next_instr=01 on the next cycle.
3. instr=EVB, arg2=3, data_avail=3, out_free=2 -> stalls in CHECK_INSTR; out_free=3 -> fires. Repeat with instr=RST, data_avail=0, out_free=0 -> fires immediately.
4. Model never asserts done, timeout_cycles=16 -> timeout_err=1 and busy=0 16 cycles after start; no further start_fsm2 until rst pulse.
5. instr=8'd7 -> bad_instr=1, no INSTR firing, next start_fsm2 has next_instr=00; spurious done_fsm2 in CHECK_SETUP leaves fire_count unchanged.
6. Assert rst low during WAIT_INSTR -> all outputs return to reset values asynchronously; after release with run=1, the first firing is SETUP_INSTR.

Source files
------------

// File: rtl/poly_eval_fire_scheduler_pkg.sv
// poly_eval_fire_scheduler_pkg: mode, opcode and state constants shared by the fire scheduler.
package poly_eval_fire_scheduler_pkg;
  localparam logic [1:0] SETUP_INSTR = 2'b00;
  localparam logic [1:0] INSTR = 2'b01;
  localparam logic [1:0] OUTPUT = 2'b10;
  localparam logic [7:0] STP = 8'd0;
  localparam logic [7:0] EVP = 8'd1;
  localparam logic [7:0] EVB = 8'd2;
  localparam logic [7:0] RST = 8'd3;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHECK_SETUP = 3'd1;
  localparam logic [2:0] S_FIRE_SETUP = 3'd2;
  localparam logic [2:0] S_WAIT_SETUP = 3'd3;
  localparam logic [2:0] S_CHECK_INSTR = 3'd4;
  localparam logic [2:0] S_FIRE_INSTR = 3'd5;
  localparam logic [2:0] S_WAIT_INSTR = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/poly_eval_fire_scheduler_fire_enable_check.sv
// poly_eval_fire_scheduler_fire_enable_check: per-opcode token/space check for an INSTR firing.
module poly_eval_fire_scheduler_fire_enable_check
  import poly_eval_fire_scheduler_pkg::*;
#(
  parameter int word_size = 16
) (
  input  logic [7:0]           instr,
  input  logic [4:0]           arg2,
  input  logic [word_size-1:0] data_avail,
  input  logic [word_size-1:0] out_free,
  output logic                 enable,
  output logic                 bad_instr
);
  logic [word_size:0] d, f, a;
  assign d = {1'b0, data_avail};
  assign f = {1'b0, out_free};
  assign a = (word_size + 1)'(arg2);
  // d > a is STP's data_avail >= arg2+1; f != 0 covers EVB with arg2 = 0
  assign enable = instr == STP ? d > a :
                  instr == EVP ? d != 0 && f != 0 :
                  instr == EVB ? d >= a && f >= a && f != 0 :
                  instr == RST;
  assign bad_instr = instr > RST;
endmodule

// File: rtl/poly_eval_fire_scheduler.sv
// poly_eval_fire_scheduler: CFDF parent scheduler alternating SETUP_INSTR/INSTR firings of FSM2 with a watchdog.
module poly_eval_fire_scheduler
  import poly_eval_fire_scheduler_pkg::*;
#(
  parameter int word_size = 16,
  parameter int timeout_cycles = 4096,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [word_size-1:0] pop_cmd,
  input  logic [word_size-1:0] data_avail,
  input  logic [word_size-1:0] out_free,
  input  logic [7:0]           instr,
  input  logic [4:0]           arg2,
  input  logic                 done_fsm2,
  output logic                 start_fsm2,
  output logic [1:0]           next_instr,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 bad_instr,
  output logic [cnt_width-1:0] fire_count
);
  localparam int ww = log2(timeout_cycles) + 1;
  logic [2:0] state, nxt;
  logic [ww-1:0] wd;
  logic en, bad, expired, waiting;
  poly_eval_fire_scheduler_fire_enable_check #(.word_size(word_size)) u_check (
    .instr(instr), .arg2(arg2), .data_avail(data_avail), .out_free(out_free),
    .enable(en), .bad_instr(bad)
  );
  assign waiting = state == S_WAIT_SETUP || state == S_WAIT_INSTR;
  assign expired = wd == ww'(timeout_cycles - 1);
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:        nxt = run ? S_CHECK_SETUP : S_IDLE;
      S_CHECK_SETUP: nxt = !run ? S_IDLE : pop_cmd != 0 ? S_FIRE_SETUP : S_CHECK_SETUP;
      S_FIRE_SETUP:  nxt = S_WAIT_SETUP;
      S_WAIT_SETUP:  nxt = done_fsm2 ? S_CHECK_INSTR : expired ? S_HALT : S_WAIT_SETUP;
      S_CHECK_INSTR: nxt = bad ? S_CHECK_SETUP : run && en ? S_FIRE_INSTR : S_CHECK_INSTR;
      S_FIRE_INSTR:  nxt = S_WAIT_INSTR;
      S_WAIT_INSTR:  nxt = done_fsm2 ? S_CHECK_SETUP : expired ? S_HALT : S_WAIT_INSTR;
      default:       nxt = S_HALT;
    endcase
  end
  // outputs decode the next state so they line up with the registered state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      start_fsm2 <= 1'b0;
      next_instr <= SETUP_INSTR;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      bad_instr <= 1'b0;
      fire_count <= '0;
      wd <= '0;
    end else begin
      state <= nxt;
      start_fsm2 <= nxt == S_FIRE_SETUP || nxt == S_FIRE_INSTR;
      busy <= nxt inside {S_FIRE_SETUP, S_WAIT_SETUP, S_FIRE_INSTR, S_WAIT_INSTR};
      next_instr <= nxt == S_FIRE_SETUP ? SETUP_INSTR : nxt == S_FIRE_INSTR ? INSTR : next_instr;
      wd <= nxt == S_FIRE_SETUP || nxt == S_FIRE_INSTR ? '0 : busy ? wd + 1'b1 : wd;
      if (waiting && done_fsm2) fire_count <= fire_count + 1'b1;
      if (waiting && !done_fsm2 && expired) timeout_err <= 1'b1;
      if (state == S_CHECK_INSTR && bad) bad_instr <= 1'b1;
    end
endmodule

// File: tb/tb_poly_eval_fire_scheduler.sv
// tb_poly_eval_fire_scheduler: directed checks of firing order, enable rules, watchdog and reset.
module tb_poly_eval_fire_scheduler;
  import poly_eval_fire_scheduler_pkg::*;
  logic clk = 1'b0, rst, run, done_fsm2;
  logic [15:0] pop_cmd, data_avail, out_free, fire_count;
  logic [7:0] instr;
  logic [4:0] arg2;
  logic start_fsm2, busy, timeout_err, bad_instr, seen;
  logic [1:0] next_instr;
  int checks = 0, failures = 0, bc, n;

  poly_eval_fire_scheduler #(.word_size(16), .timeout_cycles(16), .cnt_width(16)) dut (
    .clk(clk), .rst(rst), .run(run), .pop_cmd(pop_cmd), .data_avail(data_avail),
    .out_free(out_free), .instr(instr), .arg2(arg2), .done_fsm2(done_fsm2),
    .start_fsm2(start_fsm2), .next_instr(next_instr), .busy(busy),
    .timeout_err(timeout_err), .bad_instr(bad_instr), .fire_count(fire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FSM2 stand-in: answers lat cycles after the start cycle, returns busy cycles seen
  task automatic serve(input int lat, output int cnt);
    cnt = int'(busy);
    repeat (lat) begin
      tick();
      cnt += int'(busy);
    end
    done_fsm2 = 1'b1;
    tick();
    done_fsm2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; done_fsm2 = 1'b0; pop_cmd = '0; data_avail = '0; out_free = '0;
    instr = STP; arg2 = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_start", start_fsm2, 0);
    check("rst_busy", busy, 0);
    check("rst_mode", next_instr, SETUP_INSTR);
    check("rst_timeout", timeout_err, 0);
    check("rst_bad", bad_instr, 0);
    check("rst_count", fire_count, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    run = 1'b1; pop_cmd = 16'd1;
    tick();
    check("t1_no_early_start", start_fsm2, 0);
    tick();
    check("t1_start", start_fsm2, 1);
    check("t1_mode", next_instr, SETUP_INSTR);
    instr = STP; arg2 = 5'd4; data_avail = 16'd4;
    serve(5, bc);
    check("t1_busy_cycles", bc, 6);
    check("t1_busy_clear", busy, 0);
    check("t1_count", fire_count, 1);
    tick(); tick();
    check("t2_stp_stall", start_fsm2, 0);
    data_avail = 16'd5;
    tick();
    check("t2_stp_fire", start_fsm2, 1);
    check("t2_mode", next_instr, INSTR);
    serve(2, bc);
    tick();
    check("t2_setup_after", start_fsm2, 1);
    check("t2_setup_mode", next_instr, SETUP_INSTR);
    instr = EVB; arg2 = 5'd3; data_avail = 16'd3; out_free = 16'd2;
    serve(1, bc);
    tick(); tick();
    check("t3_evb_stall", start_fsm2, 0);
    out_free = 16'd3;
    tick();
    check("t3_evb_fire", start_fsm2, 1);
    check("t3_evb_mode", next_instr, INSTR);
    instr = RST; data_avail = '0; out_free = '0;
    serve(1, bc);
    tick();
    check("t3_setup", start_fsm2, 1);
    serve(1, bc);
    tick();
    check("t3_rst_fire", start_fsm2, 1);
    check("t3_rst_mode", next_instr, INSTR);
    check("t3_count", fire_count, 5);
    instr = 8'd7;
    serve(1, bc);
    tick();
    check("t5_setup", start_fsm2, 1);
    serve(1, bc);
    pop_cmd = '0;
    tick();
    check("t5_bad_flag", bad_instr, 1);
    check("t5_no_instr_fire", start_fsm2, 0);
    done_fsm2 = 1'b1;
    tick();
    done_fsm2 = 1'b0;
    check("t5_spurious_done", fire_count, 7);
    tick();
    check("t5_still_idle", start_fsm2, 0);
    instr = STP; arg2 = '0; data_avail = 16'd1; pop_cmd = 16'd1;
    tick();
    check("t5_setup_next", start_fsm2, 1);
    check("t5_setup_mode", next_instr, SETUP_INSTR);
    serve(1, bc);
    tick();
    check("t6_instr_fire", start_fsm2, 1);
    tick();
    check("t6_wait_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_mode", next_instr, SETUP_INSTR);
    check("t6_async_count", fire_count, 0);
    check("t6_async_bad", bad_instr, 0);
    tick(); tick();
    rst = 1'b1;
    n = 0;
    while (!start_fsm2 && n < 6) begin
      tick();
      n++;
    end
    check("t6_restart", start_fsm2, 1);
    check("t6_restart_mode", next_instr, SETUP_INSTR);
    repeat (15) tick();
    check("t4_busy_before", busy, 1);
    check("t4_no_early_timeout", timeout_err, 0);
    tick();
    check("t4_busy_drop", busy, 0);
    check("t4_timeout", timeout_err, 1);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= start_fsm2;
    end
    check("t4_halted", seen, 0);
    check("t4_count", fire_count, 0);
    rst = 1'b0;
    #1;
    check("t4_timeout_clear", timeout_err, 0);
    rst = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
